// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    EVT_NONE  = 2'd0,
    EVT_SHORT = 2'd1,
    EVT_LONG  = 2'd2
  } evt_code_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG_HELD = 2'd2
  } btn_state_t;

  // Convert a duration in milliseconds into a count of clock cycles.
  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
    return (clk_hz / 32'd1000) * ms;
  endfunction

endpackage : button_pkg

// File: rtl/button_conditioner_debounce_filter.sv
// debounce_filter: 2-FF synchronizer on the active-low pin followed by a
// stability counter that only moves the level after CYCLES agreeing samples.
module debounce_filter #(
  parameter int unsigned CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic din_async,
  output logic level
);

  localparam int unsigned CNT_W = $clog2(CYCLES + 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             s_btn;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;

  // Synchronize the raw pin; reset loads the released value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= din_async;
      sync2_q <= sync1_q;
    end
  end

  // Active-high synchronized button.
  assign s_btn = ~sync2_q;

  // Count consecutive disagreeing samples; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (s_btn == level_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(CYCLES - 1)) begin
      level_q <= s_btn;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign level = level_q;

endmodule : debounce_filter

// File: rtl/button_conditioner.sv
// button_conditioner: debounced level plus one-cycle press events for the
// pomodoro timer. Build option LONG_PRESS_EN enables the long-press timer
// (SHORT on release, LONG after hold); without it SHORT fires on press.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 24_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_n,
  output logic       btn_level,
  output logic       evt_valid,
  output logic [1:0] evt_code
);

  localparam int unsigned DB_CYCLES = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned LG_CYCLES = ms_to_cycles(CLK_HZ, LONG_MS);

  // Cycle counts that truncate to zero would make the counters meaningless.
  if (DB_CYCLES == 0 || LG_CYCLES == 0) begin : g_bad_cfg
    $error("button_conditioner: DB_CYCLES and LG_CYCLES must be at least 1");
  end

  logic       level_w;
  logic       level_prev_q;
  logic       rise_c;
  logic       fall_c;
  btn_state_t state_q;
  logic       evt_valid_q;
  evt_code_t  evt_code_q;

  debounce_filter #(
    .CYCLES(DB_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .din_async(button_n),
    .level    (level_w)
  );

  // Edges of the debounced level, seen one cycle after the level moves.
  assign rise_c = level_w & ~level_prev_q;
  assign fall_c = ~level_w & level_prev_q;

`ifdef LONG_PRESS_EN
  localparam int unsigned HOLD_W = $clog2(LG_CYCLES + 1);

  logic [HOLD_W-1:0] hold_q;

  // Press FSM with hold timer; release before the timer expires is SHORT.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_prev_q <= 1'b0;
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      evt_valid_q  <= 1'b0;
      evt_code_q   <= EVT_NONE;
    end else begin
      level_prev_q <= level_w;
      evt_valid_q  <= 1'b0;
      evt_code_q   <= EVT_NONE;
      case (state_q)
        ST_IDLE: begin
          if (rise_c) begin
            state_q <= ST_PRESSED;
            hold_q  <= '0;
          end
        end
        ST_PRESSED: begin
          // Release wins over timer expiry in the same cycle.
          if (fall_c) begin
            state_q     <= ST_IDLE;
            evt_valid_q <= 1'b1;
            evt_code_q  <= EVT_SHORT;
          end else if (hold_q == HOLD_W'(LG_CYCLES - 1)) begin
            state_q     <= ST_LONG_HELD;
            evt_valid_q <= 1'b1;
            evt_code_q  <= EVT_LONG;
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        ST_LONG_HELD: begin
          // LONG already reported for this press; release is silent.
          if (fall_c) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end
`else
  // Press FSM without hold timer; SHORT is reported as soon as the press settles.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_prev_q <= 1'b0;
      state_q      <= ST_IDLE;
      evt_valid_q  <= 1'b0;
      evt_code_q   <= EVT_NONE;
    end else begin
      level_prev_q <= level_w;
      evt_valid_q  <= 1'b0;
      evt_code_q   <= EVT_NONE;
      case (state_q)
        ST_IDLE: begin
          if (rise_c) begin
            state_q     <= ST_PRESSED;
            evt_valid_q <= 1'b1;
            evt_code_q  <= EVT_SHORT;
          end
        end
        ST_PRESSED: begin
          if (fall_c) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end
`endif

  assign btn_level = level_w;
  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with CLK_HZ=1000, DEBOUNCE_MS=4, LONG_MS=20.
// The reference model keeps the pin and debounced-level timelines in arrays
// and derives the expected level and events from them.
module tb_button_conditioner;

  localparam int unsigned CLK_HZ      = 1000;
  localparam int unsigned DEBOUNCE_MS = 4;
  localparam int unsigned LONG_MS     = 20;
  localparam int          DB          = 4;
`ifdef LONG_PRESS_EN
  localparam int          LG          = 20;
`endif
  localparam int          MAXC        = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       button_n = 1'b1;
  logic       btn_level;
  logic       evt_valid;
  logic [1:0] evt_code;

  always #5 clk = ~clk;

  button_conditioner #(
    .CLK_HZ     (CLK_HZ),
    .DEBOUNCE_MS(DEBOUNCE_MS),
    .LONG_MS    (LONG_MS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .button_n (button_n),
    .btn_level(btn_level),
    .evt_valid(evt_valid),
    .evt_code (evt_code)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: pin seen at each edge, debounced level after each edge.
  bit   pin_hist [MAXC];
  bit   lev_hist [MAXC];
  int   edge_n = 0;
  int   run    = 0;
`ifdef LONG_PRESS_EN
  bit   in_press   = 1'b0;
  int   press_rise = 0;
`endif
  bit         m_lvl   = 1'b0;
  bit         m_valid = 1'b0;
  logic [1:0] m_code  = 2'd0;

  // Observation bookkeeping used by scenario checks.
  int   evt_cnt   = 0;
  int   long_cnt  = 0;
  int   last_code = 0;
  int   evt_edge  = 0;
  int   rise_edge = 0;
  int   evt_age   = 0;
  int   lvl_age   = 0;
  logic last_lvl  = 1'b0;

  function automatic void model_step(input bit r, input bit pin);
    bit s, lev, rose, fell;
    edge_n++;
    m_valid = 1'b0;
    m_code  = 2'd0;
    if (r) begin
      // Synchronizer reloads "released": the last two pin samples read as 1.
      pin_hist[edge_n]   = 1'b1;
      pin_hist[edge_n-1] = 1'b1;
      lev_hist[edge_n]   = 1'b0;
      run   = 0;
      m_lvl = 1'b0;
`ifdef LONG_PRESS_EN
      in_press = 1'b0;
`endif
      return;
    end
    pin_hist[edge_n] = pin;
    // Pin reaches the filter two edges late, inverted to active-high.
    s   = (edge_n >= 2) ? ~pin_hist[edge_n-2] : 1'b0;
    lev = lev_hist[edge_n-1];
    if (s != lev) begin
      run++;
      if (run == DB) begin
        lev = s;
        run = 0;
      end
    end else begin
      run = 0;
    end
    lev_hist[edge_n] = lev;
    m_lvl = lev;
    rose = (edge_n >= 2) && lev_hist[edge_n-1] && !lev_hist[edge_n-2];
    fell = (edge_n >= 2) && !lev_hist[edge_n-1] && lev_hist[edge_n-2];
`ifdef LONG_PRESS_EN
    // A press whose debounced length is at most LG cycles is SHORT; otherwise
    // LONG fires LG+1 cycles after the level rose.
    if (rose) begin
      in_press   = 1'b1;
      press_rise = edge_n - 1;
    end else if (in_press && fell) begin
      in_press = 1'b0;
      m_valid  = 1'b1;
      m_code   = 2'd1;
    end else if (in_press && edge_n == press_rise + LG + 1) begin
      in_press = 1'b0;
      m_valid  = 1'b1;
      m_code   = 2'd2;
    end
`else
    if (rose) begin
      m_valid = 1'b1;
      m_code  = 2'd1;
    end
`endif
  endfunction

  task automatic tick(input bit r, input bit pin);
    rst      = r;
    button_n = pin;
    @(posedge clk);
    if (edge_n >= MAXC - 2) begin
      $display("FAIL cycle_budget edge=%0d exceeded limit %0d", edge_n, MAXC - 2);
      $fatal(1);
    end
    model_step(r, pin);
    #1;
    if (btn_level !== last_lvl) begin
      lvl_age = 0;
      if (btn_level === 1'b1) rise_edge = edge_n;
    end else begin
      lvl_age++;
    end
    last_lvl = btn_level;
    if (evt_valid === 1'b1) begin
      evt_cnt++;
      last_code = int'(evt_code);
      evt_edge  = edge_n;
      evt_age   = lvl_age;
      if (evt_code == 2'd2) long_cnt++;
    end
  endtask

  task automatic test_reset();
    bit [1:0] seq[$];
    for (int i = 0; i < 3; i++) seq.push_back(2'b10);
    for (int i = 0; i < 3; i++) seq.push_back(2'b00);
    for (int i = 0; i < 9; i++) seq.push_back(2'b01);
    foreach (seq[i]) begin
      tick(seq[i][1], seq[i][0]);
      n_chk++;
      if (btn_level !== m_lvl || evt_valid !== m_valid || evt_code !== m_code)
        $display("FAIL reset edge=%0d got lvl=%b v=%b code=%0d exp lvl=%b v=%b code=%0d",
                 edge_n, btn_level, evt_valid, evt_code, m_lvl, m_valid, m_code);
      else n_pass++;
      n_chk++;
      if (btn_level !== 1'b0 || evt_valid !== 1'b0 || evt_code !== 2'd0)
        $display("FAIL reset_quiet step=%0d got lvl=%b v=%b code=%0d exp lvl=0 v=0 code=0",
                 i, btn_level, evt_valid, evt_code);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    bit [1:0] seq[$];
    int fin;
    int lat = -1;
    int quiet_evt = 0;
    int e0;
    int idle = $urandom_range(3, 8);
    for (int i = 0; i < idle; i++) seq.push_back(2'b01);
    for (int sg = 0; sg < 10; sg++) begin
      seq.push_back({1'b0, sg[0]});
      seq.push_back({1'b0, sg[0]});
    end
    fin = seq.size();
    for (int i = 0; i < 10; i++) seq.push_back(2'b00);
    for (int i = 0; i < 12; i++) seq.push_back(2'b01);
    e0 = evt_cnt;
    foreach (seq[i]) begin
      tick(seq[i][1], seq[i][0]);
      n_chk++;
      if (btn_level !== m_lvl || evt_valid !== m_valid || evt_code !== m_code)
        $display("FAIL bounce edge=%0d got lvl=%b v=%b code=%0d exp lvl=%b v=%b code=%0d",
                 edge_n, btn_level, evt_valid, evt_code, m_lvl, m_valid, m_code);
      else n_pass++;
      if (i < fin && (evt_valid === 1'b1 || btn_level === 1'b1)) quiet_evt++;
      if (i >= fin && lat < 0 && btn_level === 1'b1) lat = i - fin + 1;
    end
    n_chk++;
    if (lat != 2 + DB) $display("FAIL bounce_latency got %0d exp %0d", lat, 2 + DB);
    else n_pass++;
    n_chk++;
    if (quiet_evt != 0) $display("FAIL bounce_quiet got %0d activity cycles exp 0", quiet_evt);
    else n_pass++;
    n_chk++;
    if (evt_cnt - e0 != 1 || last_code != 1)
      $display("FAIL bounce_event got count=%0d code=%0d exp count=1 code=1", evt_cnt - e0, last_code);
    else n_pass++;
  endtask

  task automatic test_short_press();
    for (int it = 0; it < 6; it++) begin
      bit [1:0] seq[$];
      int h = $urandom_range(6, 15);
      int g = $urandom_range(10, 16);
      int e0 = evt_cnt;
      int l0 = long_cnt;
      for (int i = 0; i < h; i++) seq.push_back(2'b00);
      for (int i = 0; i < g; i++) seq.push_back(2'b01);
      foreach (seq[i]) begin
        tick(seq[i][1], seq[i][0]);
        n_chk++;
        if (btn_level !== m_lvl || evt_valid !== m_valid || evt_code !== m_code)
          $display("FAIL short_press edge=%0d got lvl=%b v=%b code=%0d exp lvl=%b v=%b code=%0d",
                   edge_n, btn_level, evt_valid, evt_code, m_lvl, m_valid, m_code);
        else n_pass++;
      end
      n_chk++;
      if (evt_cnt - e0 != 1 || long_cnt != l0 || last_code != 1)
        $display("FAIL short_count hold=%0d got count=%0d code=%0d exp count=1 code=1",
                 h, evt_cnt - e0, last_code);
      else n_pass++;
      n_chk++;
      if (evt_age != 1)
        $display("FAIL short_timing hold=%0d got %0d cycles after level edge exp 1", h, evt_age);
      else n_pass++;
    end
  endtask

`ifdef LONG_PRESS_EN
  task automatic test_long_press();
    int holds [4] = '{60, LG, LG + 1, 10};
    int codes [4] = '{2, 1, 2, 1};
    for (int t = 0; t < 4; t++) begin
      bit [1:0] seq[$];
      int e0 = evt_cnt;
      for (int i = 0; i < holds[t]; i++) seq.push_back(2'b00);
      for (int i = 0; i < 14; i++) seq.push_back(2'b01);
      foreach (seq[i]) begin
        tick(seq[i][1], seq[i][0]);
        n_chk++;
        if (btn_level !== m_lvl || evt_valid !== m_valid || evt_code !== m_code)
          $display("FAIL long_press edge=%0d got lvl=%b v=%b code=%0d exp lvl=%b v=%b code=%0d",
                   edge_n, btn_level, evt_valid, evt_code, m_lvl, m_valid, m_code);
        else n_pass++;
      end
      n_chk++;
      if (evt_cnt - e0 != 1 || last_code != codes[t])
        $display("FAIL long_count hold=%0d got count=%0d code=%0d exp count=1 code=%0d",
                 holds[t], evt_cnt - e0, last_code, codes[t]);
      else n_pass++;
      n_chk++;
      if (codes[t] == 2) begin
        // Timer starts when the FSM sees the rise, one cycle after the level moves.
        if (evt_edge - rise_edge != LG + 1)
          $display("FAIL long_timing hold=%0d got %0d cycles after rise exp %0d",
                   holds[t], evt_edge - rise_edge, LG + 1);
        else n_pass++;
      end else begin
        if (evt_age != 1)
          $display("FAIL long_short_timing hold=%0d got %0d cycles after fall exp 1",
                   holds[t], evt_age);
        else n_pass++;
      end
    end
  endtask
`else
  task automatic test_no_long();
    bit [1:0] seq[$];
    int e0 = evt_cnt;
    int l0 = long_cnt;
    for (int i = 0; i < 60; i++) seq.push_back(2'b00);
    for (int i = 0; i < 14; i++) seq.push_back(2'b01);
    foreach (seq[i]) begin
      tick(seq[i][1], seq[i][0]);
      n_chk++;
      if (btn_level !== m_lvl || evt_valid !== m_valid || evt_code !== m_code)
        $display("FAIL no_long edge=%0d got lvl=%b v=%b code=%0d exp lvl=%b v=%b code=%0d",
                 edge_n, btn_level, evt_valid, evt_code, m_lvl, m_valid, m_code);
      else n_pass++;
    end
    n_chk++;
    if (evt_cnt - e0 != 1 || last_code != 1 || long_cnt != l0)
      $display("FAIL no_long_count got count=%0d code=%0d longs=%0d exp count=1 code=1 longs=0",
               evt_cnt - e0, last_code, long_cnt - l0);
    else n_pass++;
    n_chk++;
    if (evt_edge - rise_edge != 1)
      $display("FAIL no_long_timing got %0d cycles after rise exp 1", evt_edge - rise_edge);
    else n_pass++;
  endtask
`endif

  task automatic test_reset_mid_press();
    bit [1:0] seq[$];
    int rst_idx;
    int e_before = 0;
    for (int i = 0; i < 2 + DB + 10; i++) seq.push_back(2'b00);
    rst_idx = seq.size();
    seq.push_back(2'b10);
    for (int i = 0; i < 8; i++) seq.push_back(2'b00);
    for (int i = 0; i < 14; i++) seq.push_back(2'b01);
    foreach (seq[i]) begin
      tick(seq[i][1], seq[i][0]);
      n_chk++;
      if (btn_level !== m_lvl || evt_valid !== m_valid || evt_code !== m_code)
        $display("FAIL reset_mid edge=%0d got lvl=%b v=%b code=%0d exp lvl=%b v=%b code=%0d",
                 edge_n, btn_level, evt_valid, evt_code, m_lvl, m_valid, m_code);
      else n_pass++;
      if (i == rst_idx) begin
        e_before = evt_cnt;
        n_chk++;
        if (btn_level !== 1'b0 || evt_valid !== 1'b0)
          $display("FAIL reset_mid_clear got lvl=%b v=%b exp lvl=0 v=0", btn_level, evt_valid);
        else n_pass++;
      end
    end
    n_chk++;
    if (evt_cnt - e_before != 1 || last_code != 1)
      $display("FAIL reset_mid_count got count=%0d code=%0d exp count=1 code=1",
               evt_cnt - e_before, last_code);
    else n_pass++;
  endtask

  task automatic test_random();
    bit [1:0] seq[$];
    bit p = 1'b1;
    while (seq.size() < 600) begin
      int len = $urandom_range(1, 30);
      if ($urandom_range(0, 39) == 0) seq.push_back({1'b1, p});
      for (int i = 0; i < len; i++) seq.push_back({1'b0, p});
      p = ~p;
    end
    for (int i = 0; i < 16; i++) seq.push_back(2'b01);
    foreach (seq[i]) begin
      tick(seq[i][1], seq[i][0]);
      n_chk++;
      if (btn_level !== m_lvl || evt_valid !== m_valid || evt_code !== m_code)
        $display("FAIL random edge=%0d got lvl=%b v=%b code=%0d exp lvl=%b v=%b code=%0d",
                 edge_n, btn_level, evt_valid, evt_code, m_lvl, m_valid, m_code);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_short_press();
`ifdef LONG_PRESS_EN
    test_long_press();
`else
    test_no_long();
`endif
    test_reset_mid_press();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_button_conditioner
